// File: rtl/shru_seq_if.sv
// Handshake/bus bundle for shru_seq: save/load requests, shadow register-file
// ports and the data-cache request/response channel.
interface shru_seq_if #(
  parameter int unsigned XLEN = 64
);
  logic            save_valid_i;
  logic            save_ready_o;
  logic [XLEN-1:0] esf_base_i;
  logic            load_valid_i;
  logic            load_ack_o;

  logic [4:0]      rf_raddr_o;
  logic [XLEN-1:0] rf_rdata_i;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;

  logic            req_valid_o;
  logic            req_ready_i;
  logic            req_we_o;
  logic [XLEN-1:0] req_addr_o;
  logic [XLEN-1:0] req_wdata_o;
  logic            rsp_valid_i;
  logic [XLEN-1:0] rsp_rdata_i;

  logic [4:0]      save_level_o;
  logic [4:0]      load_level_o;
  logic            busy_o;

  modport slave (
    input  save_valid_i, esf_base_i, load_valid_i, rf_rdata_i,
           req_ready_i, rsp_valid_i, rsp_rdata_i,
    output save_ready_o, load_ack_o, rf_raddr_o, rf_we_o, rf_waddr_o,
           rf_wdata_o, req_valid_o, req_we_o, req_addr_o, req_wdata_o,
           save_level_o, load_level_o, busy_o
  );

  modport master (
    output save_valid_i, esf_base_i, load_valid_i, rf_rdata_i,
           req_ready_i, rsp_valid_i, rsp_rdata_i,
    input  save_ready_o, load_ack_o, rf_raddr_o, rf_we_o, rf_waddr_o,
           rf_wdata_o, req_valid_o, req_we_o, req_addr_o, req_wdata_o,
           save_level_o, load_level_o, busy_o
  );
endinterface

// File: rtl/shru_seq.sv
// Shadow-register spill/restore sequencer between a shadow GPR file and the
// data cache. Define SHRU_SEQ_LOAD_EN to build the restore (load) path.
module shru_seq #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NR_REGS = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  shru_seq_if.slave  bus
);

  localparam logic [XLEN-1:0] STRIDE   = XLEN'(XLEN / 8);
  localparam logic [4:0]      LAST_IDX = 5'(NR_REGS);

`ifdef SHRU_SEQ_LOAD_EN
  typedef enum logic [1:0] {IDLE, SAVE, LD_REQ, LD_WAIT} state_e;
`else
  typedef enum logic [1:0] {IDLE, SAVE} state_e;
`endif

  state_e          state_q;
  logic [4:0]      idx_q;
  logic [XLEN-1:0] addr_q;
  logic            save_ready_q;
  logic            busy_q;
  logic            req_valid_q;
  logic            req_we_q;
  logic [4:0]      save_lvl_q;
`ifdef SHRU_SEQ_LOAD_EN
  logic [4:0]      load_lvl_q;
`endif

  // addr_q tracks base + (idx-1)*stride incrementally; wraps modulo 2^XLEN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      save_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      save_lvl_q   <= '0;
`ifdef SHRU_SEQ_LOAD_EN
      load_lvl_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.save_valid_i) begin
            state_q      <= SAVE;
            idx_q        <= 5'd1;
            addr_q       <= bus.esf_base_i;
            save_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            req_valid_q  <= 1'b1;
            req_we_q     <= 1'b1;
            save_lvl_q   <= 5'd1;
          end
`ifdef SHRU_SEQ_LOAD_EN
          else if (bus.load_valid_i) begin
            state_q      <= LD_REQ;
            idx_q        <= 5'd1;
            addr_q       <= bus.esf_base_i;
            save_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            req_valid_q  <= 1'b1;
            req_we_q     <= 1'b0;
            load_lvl_q   <= 5'd1;
          end
`endif
        end

        SAVE: begin
          if (bus.req_ready_i) begin
            if (idx_q == LAST_IDX) begin
              state_q      <= IDLE;
              idx_q        <= '0;
              addr_q       <= '0;
              save_ready_q <= 1'b1;
              busy_q       <= 1'b0;
              req_valid_q  <= 1'b0;
              req_we_q     <= 1'b0;
              save_lvl_q   <= '0;
            end else begin
              idx_q      <= idx_q + 5'd1;
              addr_q     <= addr_q + STRIDE;
              save_lvl_q <= idx_q + 5'd1;
            end
          end
        end

`ifdef SHRU_SEQ_LOAD_EN
        LD_REQ: begin
          if (bus.req_ready_i) begin
            state_q     <= LD_WAIT;
            req_valid_q <= 1'b0;
          end
        end

        LD_WAIT: begin
          if (bus.rsp_valid_i) begin
            if (idx_q == LAST_IDX) begin
              state_q      <= IDLE;
              idx_q        <= '0;
              addr_q       <= '0;
              save_ready_q <= 1'b1;
              busy_q       <= 1'b0;
              load_lvl_q   <= '0;
            end else begin
              state_q     <= LD_REQ;
              idx_q       <= idx_q + 5'd1;
              addr_q      <= addr_q + STRIDE;
              req_valid_q <= 1'b1;
              load_lvl_q  <= idx_q + 5'd1;
            end
          end
        end
`endif

        default: ;
      endcase
    end
  end

  assign bus.save_ready_o = save_ready_q;
  assign bus.busy_o       = busy_q;
  assign bus.req_valid_o  = req_valid_q;
  assign bus.req_we_o     = req_we_q;
  assign bus.req_addr_o   = req_valid_q ? addr_q : '0;
  // Store data comes straight from the combinational shadow-RF read port.
  assign bus.req_wdata_o  = req_we_q ? bus.rf_rdata_i : '0;
  assign bus.rf_raddr_o   = save_lvl_q;
  assign bus.save_level_o = save_lvl_q;

`ifdef SHRU_SEQ_LOAD_EN
  logic rf_we;

  assign rf_we            = (state_q == LD_WAIT) && bus.rsp_valid_i;
  assign bus.load_ack_o   = (state_q == IDLE) && bus.load_valid_i && !bus.save_valid_i;
  assign bus.rf_we_o      = rf_we;
  assign bus.rf_waddr_o   = rf_we ? idx_q : '0;
  assign bus.rf_wdata_o   = rf_we ? bus.rsp_rdata_i : '0;
  assign bus.load_level_o = load_lvl_q;
`else
  logic unused_load_inputs;

  assign unused_load_inputs = ^{bus.load_valid_i, bus.rsp_valid_i, bus.rsp_rdata_i};
  assign bus.load_ack_o     = 1'b0;
  assign bus.rf_we_o        = 1'b0;
  assign bus.rf_waddr_o     = '0;
  assign bus.rf_wdata_o     = '0;
  assign bus.load_level_o   = '0;
`endif

endmodule

// File: tb/tb_shru_seq.sv
// Self-checking bench for shru_seq (XLEN=64, NR_REGS=4); load scenarios are
// built only when SHRU_SEQ_LOAD_EN is defined.
module tb_shru_seq;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NR   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] rf_mem [0:31];
  logic [63:0] mem_salt;

  shru_seq_if #(.XLEN(XLEN)) bus ();

  shru_seq #(.XLEN(XLEN), .NR_REGS(NR)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.rf_rdata_i = rf_mem[bus.rf_raddr_o];

  // Frame memory contents as seen by loads: a fixed scramble of the address.
  function automatic logic [63:0] mem_of(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0F0F, ~a[63:32]} ^ mem_salt;
  endfunction

  function automatic logic [217:0] out_vec();
    return {bus.save_ready_o, bus.load_ack_o, bus.rf_we_o, bus.req_valid_o,
            bus.req_we_o, bus.busy_o, bus.rf_raddr_o, bus.rf_waddr_o,
            bus.save_level_o, bus.load_level_o, bus.rf_wdata_o,
            bus.req_addr_o, bus.req_wdata_o};
  endfunction

  task automatic quiet_inputs();
    bus.save_valid_i = 1'b0;
    bus.load_valid_i = 1'b0;
    bus.esf_base_i   = '0;
    bus.req_ready_i  = 1'b0;
    bus.rsp_valid_i  = 1'b0;
    bus.rsp_rdata_i  = '0;
  endtask

  // Runs from the first SAVE cycle; stops early once idx reaches abort_at.
  task automatic save_body(input logic [63:0] base, input int mode,
                           input int abort_at, output int cycles);
    int k;
    int stall;
    logic [63:0] exp_addr;
    k = 1; stall = 0; cycles = 0;
    while (k <= int'(NR) && k != abort_at && cycles < 200) begin
      @(negedge clk);
      bus.save_valid_i = 1'b0;
      bus.esf_base_i   = {$urandom, $urandom};
      case (mode)
        0:       bus.req_ready_i = 1'b1;
        1:       bus.req_ready_i = !(k == 2 && stall < 3);
        default: bus.req_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      bus.rsp_valid_i = 1'($urandom_range(0, 1));
      bus.rsp_rdata_i = {$urandom, $urandom};
      #1;
      exp_addr = base + 64'((k - 1) * 8);
      checks++;
      if (bus.req_valid_o !== 1'b1 || bus.req_we_o !== 1'b1 ||
          bus.req_addr_o !== exp_addr || bus.req_wdata_o !== rf_mem[k]) begin
        errors++;
        $display("FAIL save_req k=%0d: valid=%b we=%b addr=%h wdata=%h, want 1 1 %h %h",
                 k, bus.req_valid_o, bus.req_we_o, bus.req_addr_o, bus.req_wdata_o,
                 exp_addr, rf_mem[k]);
      end
      checks++;
      if (bus.save_level_o !== 5'(k) || bus.rf_raddr_o !== 5'(k) ||
          bus.load_level_o !== 5'd0 || bus.busy_o !== 1'b1 ||
          bus.save_ready_o !== 1'b0 || bus.load_ack_o !== 1'b0 || bus.rf_we_o !== 1'b0) begin
        errors++;
        $display("FAIL save_state k=%0d: slvl=%0d raddr=%0d llvl=%0d busy=%b srdy=%b ack=%b rfwe=%b, want %0d %0d 0 1 0 0 0",
                 k, bus.save_level_o, bus.rf_raddr_o, bus.load_level_o, bus.busy_o,
                 bus.save_ready_o, bus.load_ack_o, bus.rf_we_o, k, k);
      end
      if (bus.req_ready_i) k++;
      else stall++;
      cycles++;
    end
    if (k <= int'(NR) && k != abort_at) begin
      errors++; checks++;
      $display("FAIL save_timeout: idx=%0d after %0d cycles, want completion", k, cycles);
    end
  endtask

  task automatic save_idle_check(input string name);
    @(negedge clk);
    bus.save_valid_i = 1'b0;
    bus.req_ready_i  = 1'b1;
    #1;
    checks++;
    if (bus.save_ready_o !== 1'b1 || bus.busy_o !== 1'b0 ||
        bus.req_valid_o !== 1'b0 || bus.save_level_o !== 5'd0) begin
      errors++;
      $display("FAIL %s_idle: srdy=%b busy=%b rvalid=%b slvl=%0d, want 1 0 0 0",
               name, bus.save_ready_o, bus.busy_o, bus.req_valid_o, bus.save_level_o);
    end
  endtask

  task automatic test_reset();
    logic [217:0] exp_v;
    exp_v = '0;
    exp_v[217] = 1'b1;
    quiet_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_vec() !== exp_v) begin
      errors++;
      $display("FAIL reset_async: outputs=%h, want %h", out_vec(), exp_v);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_vec() !== exp_v) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h, want %h", out_vec(), exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_save(input logic [63:0] base);
    @(negedge clk);
    bus.save_valid_i = 1'b1;
    bus.esf_base_i   = base;
    #1;
    checks++;
    if (bus.save_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL save_handshake: srdy=%b busy=%b, want 1 0", bus.save_ready_o, bus.busy_o);
    end
  endtask

  task automatic test_save_basic();
    int cyc;
    start_save(64'h8000_1000);
    save_body(64'h8000_1000, 0, 0, cyc);
    checks++;
    if (cyc != int'(NR)) begin
      errors++;
      $display("FAIL save_latency: %0d cycles, want %0d", cyc, NR);
    end
    save_idle_check("save_basic");
  endtask

  task automatic test_save_stall();
    int cyc;
    start_save(64'h8000_1000);
    save_body(64'h8000_1000, 1, 0, cyc);
    checks++;
    if (cyc != int'(NR) + 3) begin
      errors++;
      $display("FAIL save_stall_len: %0d cycles, want %0d", cyc, NR + 3);
    end
    save_idle_check("save_stall");
  endtask

  task automatic test_save_wrap();
    int cyc;
    start_save(64'hFFFF_FFFF_FFFF_FFF0);
    save_body(64'hFFFF_FFFF_FFFF_FFF0, 2, 0, cyc);
    save_idle_check("save_wrap");
  endtask

  task automatic test_reset_mid_save();
    int cyc;
    logic [217:0] exp_v;
    exp_v = '0;
    exp_v[217] = 1'b1;
    start_save(64'h0000_4000);
    save_body(64'h0000_4000, 0, 2, cyc);
    @(negedge clk);
    rst_n = 1'b0;
    bus.rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (out_vec() !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_save: outputs=%h, want %h", out_vec(), exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_save(64'h0000_5000);
    save_body(64'h0000_5000, 0, 0, cyc);
    save_idle_check("after_reset");
  endtask

`ifdef SHRU_SEQ_LOAD_EN
  // Runs from the first LD_REQ cycle; returns right after the request
  // handshake of abort_at, leaving the DUT waiting for that response.
  task automatic load_body(input logic [63:0] base, input int lat,
                           input bit rnd, input int abort_at);
    int n;
    logic [63:0] exp_addr;
    for (int k = 1; k <= int'(NR); k++) begin
      exp_addr = base + 64'((k - 1) * 8);
      n = 0;
      do begin
        @(negedge clk);
        bus.load_valid_i = 1'b0;
        bus.esf_base_i   = {$urandom, $urandom};
        bus.req_ready_i  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.rsp_valid_i  = 1'($urandom_range(0, 1));
        bus.rsp_rdata_i  = {$urandom, $urandom};
        #1;
        checks++;
        if (bus.req_valid_o !== 1'b1 || bus.req_we_o !== 1'b0 ||
            bus.req_addr_o !== exp_addr || bus.load_level_o !== 5'(k) ||
            bus.save_level_o !== 5'd0 || bus.rf_we_o !== 1'b0 ||
            bus.busy_o !== 1'b1 || bus.save_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL load_req k=%0d: valid=%b we=%b addr=%h llvl=%0d slvl=%0d rfwe=%b busy=%b srdy=%b, want 1 0 %h %0d 0 0 1 0",
                   k, bus.req_valid_o, bus.req_we_o, bus.req_addr_o, bus.load_level_o,
                   bus.save_level_o, bus.rf_we_o, bus.busy_o, bus.save_ready_o, exp_addr, k);
        end
        n++;
      end while (!bus.req_ready_i && n < 100);
      if (!bus.req_ready_i) begin
        errors++; checks++;
        $display("FAIL load_timeout: no request handshake at idx %0d, want one", k);
        return;
      end
      if (k == abort_at) return;
      for (int w = 1; w < lat; w++) begin
        @(negedge clk);
        bus.req_ready_i = 1'($urandom_range(0, 1));
        bus.rsp_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.req_valid_o !== 1'b0 || bus.rf_we_o !== 1'b0 || bus.load_level_o !== 5'(k)) begin
          errors++;
          $display("FAIL load_wait k=%0d: rvalid=%b rfwe=%b llvl=%0d, want 0 0 %0d",
                   k, bus.req_valid_o, bus.rf_we_o, bus.load_level_o, k);
        end
      end
      @(negedge clk);
      bus.req_ready_i = 1'($urandom_range(0, 1));
      bus.rsp_valid_i = 1'b1;
      bus.rsp_rdata_i = mem_of(exp_addr);
      #1;
      checks++;
      if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'(k) ||
          bus.rf_wdata_o !== mem_of(exp_addr) || bus.req_valid_o !== 1'b0 ||
          bus.load_level_o !== 5'(k)) begin
        errors++;
        $display("FAIL load_rsp k=%0d: rfwe=%b waddr=%0d wdata=%h rvalid=%b llvl=%0d, want 1 %0d %h 0 %0d",
                 k, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.req_valid_o,
                 bus.load_level_o, k, mem_of(exp_addr), k);
      end
    end
  endtask

  task automatic start_load(input logic [63:0] base);
    @(negedge clk);
    bus.save_valid_i = 1'b0;
    bus.load_valid_i = 1'b1;
    bus.esf_base_i   = base;
    #1;
    checks++;
    if (bus.load_ack_o !== 1'b1 || bus.save_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL load_handshake: ack=%b srdy=%b, want 1 1", bus.load_ack_o, bus.save_ready_o);
    end
  endtask

  task automatic load_idle_check(input string name);
    @(negedge clk);
    bus.load_valid_i = 1'b0;
    bus.rsp_valid_i  = 1'b1;
    bus.rsp_rdata_i  = {$urandom, $urandom};
    #1;
    checks++;
    if (bus.rf_we_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.load_level_o !== 5'd0 ||
        bus.save_ready_o !== 1'b1 || bus.req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: rfwe=%b busy=%b llvl=%0d srdy=%b rvalid=%b, want 0 0 0 1 0",
               name, bus.rf_we_o, bus.busy_o, bus.load_level_o, bus.save_ready_o, bus.req_valid_o);
    end
    bus.rsp_valid_i = 1'b0;
  endtask

  task automatic test_load_basic();
    start_load(64'h2000);
    load_body(64'h2000, 2, 1'b0, 0);
    load_idle_check("load_basic");
  endtask

  task automatic test_priority();
    int cyc;
    @(negedge clk);
    bus.save_valid_i = 1'b1;
    bus.load_valid_i = 1'b1;
    bus.esf_base_i   = 64'h0000_7000;
    #1;
    checks++;
    if (bus.save_ready_o !== 1'b1 || bus.load_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL prio_ack: srdy=%b ack=%b, want 1 0", bus.save_ready_o, bus.load_ack_o);
    end
    save_body(64'h0000_7000, 0, 0, cyc);
    @(negedge clk);
    bus.esf_base_i = 64'h0000_9100;
    #1;
    checks++;
    if (bus.save_ready_o !== 1'b1 || bus.load_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL prio_load_after: srdy=%b ack=%b, want 1 1", bus.save_ready_o, bus.load_ack_o);
    end
    load_body(64'h0000_9100, 1, 1'b1, 0);
    load_idle_check("prio");
  endtask

  task automatic test_reset_mid_load();
    logic [217:0] exp_v;
    exp_v = '0;
    exp_v[217] = 1'b1;
    start_load(64'h3000);
    load_body(64'h3000, 2, 1'b0, 3);
    @(negedge clk);
    rst_n = 1'b0;
    bus.rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (out_vec() !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_load: outputs=%h, want %h", out_vec(), exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      bus.rsp_valid_i = 1'b1;
      bus.rsp_rdata_i = {$urandom, $urandom};
      #1;
      checks++;
      if (bus.rf_we_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.load_level_o !== 5'd0) begin
        errors++;
        $display("FAIL late_rsp: rfwe=%b busy=%b llvl=%0d, want 0 0 0",
                 bus.rf_we_o, bus.busy_o, bus.load_level_o);
      end
      @(negedge clk);
    end
    bus.rsp_valid_i = 1'b0;
  endtask
`else
  task automatic test_load_disabled();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.load_valid_i = 1'b1;
      bus.esf_base_i   = {$urandom, $urandom};
      bus.rsp_valid_i  = 1'($urandom_range(0, 1));
      bus.rsp_rdata_i  = {$urandom, $urandom};
      #1;
      checks++;
      if (bus.load_ack_o !== 1'b0 || bus.rf_we_o !== 1'b0 || bus.busy_o !== 1'b0 ||
          bus.load_level_o !== 5'd0 || bus.save_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL load_disabled cyc=%0d: ack=%b rfwe=%b busy=%b llvl=%0d srdy=%b, want 0 0 0 0 1",
                 i, bus.load_ack_o, bus.rf_we_o, bus.busy_o, bus.load_level_o, bus.save_ready_o);
      end
    end
    bus.load_valid_i = 1'b0;
    bus.rsp_valid_i  = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] base;
    for (int op = 0; op < 8; op++) begin
      for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
      base = {$urandom, $urandom};
      base[2:0] = 3'b000;
`ifdef SHRU_SEQ_LOAD_EN
      if ($urandom_range(0, 1) == 1) begin
        start_load(base);
        load_body(base, int'($urandom_range(1, 3)), 1'b1, 0);
        continue;
      end
`endif
      start_save(base);
      save_body(base, 2, 0, cyc);
    end
    save_idle_check("b2b");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_salt = {$urandom, $urandom};
    for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
    test_reset();
    test_save_basic();
    test_save_stall();
    test_save_wrap();
    test_reset_mid_save();
`ifdef SHRU_SEQ_LOAD_EN
    test_load_basic();
    test_priority();
    test_reset_mid_load();
`else
    test_load_disabled();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shru_seq.md
SHRU_SEQ -- requirements
Module: shru_seq

Interface
REQ-001 Parameter XLEN, default 64, data and address width in bits (32 or 64).
REQ-002 Parameter NR_REGS, default 15, number of shadowed GPRs (x1..xNR_REGS), range 1..31.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 save_valid_i / save_ready_o  in/out  1/1  request to spill shadow registers to the exception stack frame.
REQ-006 esf_base_i  in  XLEN  stack-frame base address; sampled on the save or load handshake.
REQ-007 load_valid_i / load_ack_o  in/out  1/1  request to restore registers from the frame; ack is a one-cycle pulse on acceptance.
REQ-008 rf_raddr_o / rf_rdata_i  out/in  5/XLEN  combinational shadow-register-file read port.
REQ-009 rf_we_o, rf_waddr_o, rf_wdata_o  out  1, 5, XLEN  register-file restore write port.
REQ-010 req_valid_o, req_ready_i, req_we_o, req_addr_o, req_wdata_o  out/in/out/out/out  1/1/1/XLEN/XLEN  data-cache request channel.
REQ-011 rsp_valid_i, rsp_rdata_i  in  1/XLEN  data-cache load response.
REQ-012 save_level_o, load_level_o  out  5/5  next register index still pending in save/load; 0 when not in that operation.
REQ-013 busy_o  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SAVE, LD_REQ and LD_WAIT.
REQ-015 IDLE: save_ready_o=1; save handshake -> SAVE with idx=1, base latched; otherwise load_valid_i -> LD_REQ with idx=1, base latched, load_ack_o=1 for that cycle.
REQ-016 When save_valid_i and load_valid_i are both high in IDLE, save SHALL win; the load is not acknowledged that cycle.
REQ-017 SAVE: req_valid_o=1, req_we_o=1, rf_raddr_o=idx, req_wdata_o=rf_rdata_i, req_addr_o=base+(idx-1)*(XLEN/8).
REQ-018 On each SAVE handshake (req_valid_o & req_ready_i), idx SHALL increment; the handshake at idx=NR_REGS SHALL return the FSM to IDLE.
REQ-019 With req_ready_i held at 1, a save of N registers SHALL take exactly N cycles, and save_ready_o SHALL be 1 in the following cycle.
REQ-020 LD_REQ: req_valid_o=1, req_we_o=0, same address formula; on handshake -> LD_WAIT.
REQ-021 LD_WAIT: req_valid_o=0; on rsp_valid_i, rf_we_o=1, rf_waddr_o=idx, rf_wdata_o=rsp_rdata_i; then idx=NR_REGS -> IDLE, else idx+1 -> LD_REQ.
REQ-022 At most one load SHALL be outstanding; rsp_valid_i outside LD_WAIT SHALL be ignored.
REQ-023 save_ready_o SHALL be 0 in every state except IDLE; save_valid_i and load_valid_i are not accepted while busy.
REQ-024 req_valid_o, once asserted, SHALL hold with stable addr/data/we until the handshake.
REQ-025 Address arithmetic SHALL wrap modulo 2^XLEN, with no error flag.
REQ-026 save_level_o=idx in SAVE, else 0; load_level_o=idx in LD_REQ/LD_WAIT, else 0.

Reset
REQ-027 On rst_ni low, at any time including mid-operation, the block SHALL enter IDLE with idx=0 and base=0, and all outputs SHALL be 0 except save_ready_o=1.
REQ-028 A save or load interrupted by reset SHALL be abandoned without resumption; a pending rsp_valid_i after reset SHALL be ignored.

Configuration
REQ-029 Macro SHRU_SEQ_LOAD_EN defined: load path (LD_REQ, LD_WAIT, rf write, load_ack_o) fully implemented.
REQ-030 SHRU_SEQ_LOAD_EN undefined: load states removed; load_valid_i ignored; load_ack_o, rf_we_o and load_level_o tied to 0; save behaviour unchanged.

Verification
REQ-031 XLEN=64, NR_REGS=4, base=0x8000_1000, req_ready_i=1, save pulse -> stores at 0x8000_1000/1008/1010/1018 with data of x1..x4 on 4 consecutive cycles; save_ready_o=1 on cycle 5.
REQ-032 Same save, req_ready_i low for 3 cycles at idx=2 -> addr 0x8000_1008 and data held stable; save_level_o=2 throughout the stall.
REQ-033 Load, base=0x2000, rsp latency 2 -> reads 0x2000..0x2018 serially; rf writes x1..x4 with response data; load_level_o counts 1..4, then 0.
REQ-034 save_valid_i and load_valid_i high together in IDLE -> save executes, load_ack_o=0; load is accepted in the first IDLE cycle afterwards.
REQ-035 rst_ni low during LD_WAIT at idx=3 -> next cycle IDLE, all outputs 0 except save_ready_o=1; a late rsp_valid_i causes no rf write.
REQ-036 Build without SHRU_SEQ_LOAD_EN, load_valid_i=1 for 10 cycles -> load_ack_o=0, rf_we_o=0, busy_o=0.
